movwide_sequencer: RTL
======================

# movwide_sequencer

Decomposes a 64-bit constant into an ordered stream of 16-bit halfword beats, each a {fixed, shamt, clear} tuple in the form the wide-move datapath consumes: place `fixed` at bit offset `shamt*16`, optionally zeroing the rest of the register. It is the producer side of that interface and sits between the constant/literal source (decode or test harness) and the MOVZ/MOVK execution path. The first beat always clears the register (MOVZ); every later beat keeps it (MOVK). It uses valid/ready handshakes on both sides and holds one word at a time.

## Interface
- No parameters. Data width is fixed at 64 bits and halfword width at 16 bits.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high. Sampled on the rising edge of `clk`.
- `in_valid` input 1: `in_data` holds a word to decompose.
- `in_ready` output 1: the block accepts a word this cycle.
- `in_data` input 64: the constant to decompose.
- `out_valid` output 1: the current beat is valid.
- `out_ready` input 1: the consumer accepts the current beat.
- `out_fixed` output 16: the halfword value.
- `out_shamt` output 2: the halfword index; the bit offset is `out_shamt*16`.
- `out_clear` output 1: 1 means zero all other bits (MOVZ); 0 means keep them (MOVK).
- `out_last` output 1: this is the final beat for the current word.

## Operation
- States: IDLE and EMIT.
- **IDLE**
  - `in_ready=1`, `out_valid=0`.
  - When `in_valid & in_ready`: latch `in_data` into `word`, compute `pend[3:0]`, set `first=1`, then go to EMIT.
  - `pend[i]` is 1 when halfword `i` (bits 16i+15:16i) is to be emitted.
- **EMIT**
  - `in_ready=0`, `out_valid=1`. `in_valid` is ignored.
  - `idx` is the lowest set bit of `pend`.
  - `out_fixed = word[16*idx +: 16]`, `out_shamt = idx`, `out_clear = first`.
  - `out_last = 1` when `pend` has exactly one set bit.
- **Beat handshake in EMIT**
  - On `out_valid & out_ready`: clear `pend[idx]` and set `first=0`.
  - If `out_last`, go to IDLE.
- **Zero word**
  - When the computed `pend` is 0000, force `pend=0001`.
  - Result: exactly one beat, fixed=0, shamt=0, clear=1, last=1.
- **Ordering**
  - Beats are always emitted in ascending `shamt` order.
  - Exactly one beat per word has clear=1, and it is the first beat.
  - Exactly one beat per word has last=1, and it is the final beat.
- **Backpressure**
  - While `out_valid & !out_ready`, every `out_*` signal holds its value and no state changes.
- All outputs are registered or decoded from registers only. There is no combinational path from `in_*` to `out_*` or from `out_ready` to `in_ready`.

## Timing
- **Reset**
  - After a reset edge: state=IDLE, `in_ready=1`, `out_valid=0`, `out_fixed=0`, `out_shamt=0`, `out_clear=0`, `out_last=0`.
  - `word`, `pend` and `first` are cleared.
- **Latency**
  - A word accepted at edge N produces its first beat valid in the cycle after edge N.
  - An N-beat word with `out_ready` held high occupies exactly N cycles of `out_valid`.
- **Turnaround**
  - The last beat is accepted at edge M; `in_ready=1` in the cycle after edge M.
  - The minimum word period is therefore beats+1 cycles.
- **Reset mid-operation**
  - Reset takes priority over every handshake.
  - An in-flight word is discarded with no further beats.
  - A simultaneous `in_valid` is not accepted.

## Configuration
- `MOVSEQ_SKIP_ZERO_EN` defined:
  - `pend[i] = (halfword i != 0)`, with the zero-word rule applied.
  - Each word produces 1 to 4 beats.
- `MOVSEQ_SKIP_ZERO_EN` undefined:
  - `pend=1111` always.
  - Every word produces exactly 4 beats (shamt 0,1,2,3, clear on shamt 0 only), including zero halfwords.
  - The zero-word rule is unreachable.

## Test plan
- **Zero word.** `in_data=0x0000_0000_0000_0000`, `out_ready=1`, macro on → one beat (0x0000, 0, clear=1, last=1). `in_ready` returns high the next cycle.
- **Sparse word.** `in_data=0x1234_0000_0000_5678`, macro on → two beats: (0x5678, 0, clear=1, last=0) then (0x1234, 3, clear=0, last=1).
- **Skip low halfword.** `in_data=0x0000_0000_ABCD_0000`, macro on → one beat (0xABCD, 1, clear=1, last=1). This checks that clear follows the first *emitted* beat, not shamt 0.
- **Backpressure.** `in_data=0xDEAD_BEEF_CAFE_F00D`, with `out_ready` held low for 3 cycles during the beat at shamt=1.
  - Required beats: F00D/0/1, CAFE/1/0, BEEF/2/0, DEAD/3/0/last.
  - During the stall, outputs hold 0xCAFE/1/0/0.
  - An `in_valid` pulse with 0xFFFF_FFFF_FFFF_FFFF during EMIT is not accepted.
- **Reset mid-word.** Same word as the backpressure case; assert `reset` for one cycle while the beat at shamt=2 is pending.
  - Next cycle: `out_valid=0`, `in_ready=1`.
  - A following word 0x0001 produces a single beat (0x0001, 0, 1, last=1).
- **Macro off.** `in_data=0x0000_0000_0001_0000` → four beats: (0,0,clear=1), (0x0001,1,0), (0,2,0), (0,3,0,last=1), over four consecutive cycles with `out_ready=1`.

Source files
------------

// File: rtl/movwide_sequencer.sv
// -----------------------------------------------------------------------------
// movwide_sequencer
//
// Splits a 64-bit constant into an ordered stream of 16-bit halfword beats for
// the wide-move (MOVZ/MOVK) execution path. Each beat is a {fixed, shamt,
// clear} tuple: the consumer places `fixed` at bit offset shamt*16 and, when
// `clear` is set, zeroes the rest of the register. The first beat of every
// word clears (MOVZ) and all later beats keep (MOVK). Beats always leave in
// ascending shamt order. One word is held at a time.
//
// Configuration macro:
//   MOVSEQ_SKIP_ZERO_EN  defined   : zero halfwords are skipped (1..4 beats);
//                                    an all-zero word still emits one beat
//                                    (0x0000, shamt 0, clear, last).
//                        undefined : every word emits exactly 4 beats.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-high
//   in_valid   in   1   in_data holds a word to decompose
//   in_ready   out  1   a word is accepted this cycle (IDLE)
//   in_data    in  64   constant to decompose
//   out_valid  out  1   current beat is valid (EMIT)
//   out_ready  in   1   consumer takes the current beat
//   out_fixed  out 16   halfword value
//   out_shamt  out  2   halfword index (bit offset = out_shamt*16)
//   out_clear  out  1   1 = MOVZ (zero other bits), 0 = MOVK (keep)
//   out_last   out  1   final beat of the current word
//
// All outputs are decoded from registers only; there is no combinational
// path from in_* to out_* or from out_ready to in_ready.
// -----------------------------------------------------------------------------
module movwide_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_fixed,
  output logic [1:0]  out_shamt,
  output logic        out_clear,
  output logic        out_last
);

  localparam int unsigned HW_W = 16;
  localparam int unsigned N_HW = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [63:0]       word_q,  word_d;
  logic [N_HW-1:0]   pend_q,  pend_d;
  logic              first_q, first_d;

  // ---------------------------------------------------------------------------
  // Decode of the registered word
  // ---------------------------------------------------------------------------
  logic [1:0]        idx;         // lowest pending halfword
  logic [N_HW-1:0]   idx_onehot;  // idx as a mask into pend
  logic              one_left;    // exactly one pending halfword remains
  logic [HW_W-1:0]   hw_sel;      // halfword selected by idx
  logic [N_HW-1:0]   pend_init;   // pending mask for a newly accepted word

  // Lowest set bit of pend: scanning from the top down lets the lowest
  // set index overwrite the higher ones. An empty mask decodes to 0.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx = 2'd0;
    for (int i = N_HW - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        idx = 2'(i);
      end
    end
  end

  assign idx_onehot = 4'b0001 << idx;

  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign one_left = (pend_q != '0) && ((pend_q & (pend_q - 4'd1)) == '0);

  always_comb begin
    hw_sel = word_q[15:0];
    case (idx)
      2'd0:    hw_sel = word_q[15:0];
      2'd1:    hw_sel = word_q[31:16];
      2'd2:    hw_sel = word_q[47:32];
      default: hw_sel = word_q[63:48];
    endcase
  end

  // Pending mask for the word on in_data.
  always_comb begin
    pend_init = '1;
`ifdef MOVSEQ_SKIP_ZERO_EN
    for (int i = 0; i < N_HW; i++) begin
      pend_init[i] = |in_data[i*HW_W +: HW_W];
    end
    // An all-zero word still needs one MOVZ beat to zero the register.
    if (pend_init == '0) begin
      pend_init = 4'b0001;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of the
  // order the simulator evaluates processes in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      pend_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pend_q  <= pend_d;
      first_q <= first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pend_d  = pend_q;
    first_d = first_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          pend_d  = pend_init;
          first_d = 1'b1;
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        // A stalled beat (out_ready low) changes nothing, so every output
        // holds until the consumer takes it.
        if (out_ready) begin
          pend_d  = pend_q & ~idx_onehot;
          first_d = 1'b0;
          if (one_left) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Beat fields are forced to zero outside EMIT so an idle or freshly reset
  // block presents an all-zero beat.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_fixed = '0;
    out_shamt = '0;
    out_clear = 1'b0;
    out_last  = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end

      S_EMIT: begin
        out_valid = 1'b1;
        out_fixed = hw_sel;
        out_shamt = idx;
        out_clear = first_q;
        out_last  = one_left;
      end

      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule
